// File: rtl/dpram_pkg.sv
// Shared types and helpers for the parametrised dual-port RAM.
// lane_merge is width-agnostic: callers zero-extend to MAX_W and truncate the result.
package dpram_pkg;

   localparam int unsigned LANE_W    = 8;
   localparam int unsigned MAX_W     = 256;
   localparam int unsigned MAX_LANES = MAX_W / LANE_W;

   typedef enum logic [1:0] {
      NO_CHANGE   = 2'd0,
      READ_FIRST  = 2'd1,
      WRITE_FIRST = 2'd2
   } rdw_mode_e;

   // Replace every byte lane whose enable is set; keep the rest of old_w.
   function automatic logic [MAX_W-1:0] lane_merge(
      input logic [MAX_W-1:0]     old_w,
      input logic [MAX_W-1:0]     new_w,
      input logic [MAX_LANES-1:0] be
   );
      logic [MAX_W-1:0] res;
      res = old_w;
      for (int i = 0; i < int'(MAX_LANES); i++) begin
         if (be[i]) res[i*LANE_W +: LANE_W] = new_w[i*LANE_W +: LANE_W];
      end
      return res;
   endfunction

endpackage

// File: rtl/dual_port_ram_param_rd_pipe.sv
// Optional second read register stage for one port, with its valid and reset flush.
module dpram_rd_pipe #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              s1_vld,
   input  logic [DATA_W-1:0] s1_data,
   output logic [DATA_W-1:0] q,
   output logic              qv
);

   logic [DATA_W-1:0] s2_data;
   logic              s2_vld;

   // Stage 2 advances every cycle; data only reloads on a valid beat so q holds otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_vld  <= 1'b0;
         s2_data <= '0;
      end else begin
         s2_vld <= s1_vld;
         if (s1_vld) s2_data <= s1_data;
      end
   end

   always_comb begin
      q  = s1_data;
      qv = s1_vld;
      if (RD_LAT == 2) begin
         q  = s2_data;
         qv = s2_vld;
      end
   end

endmodule

// File: rtl/dual_port_ram_param.sv
// True dual-port synchronous RAM with byte lanes, selectable read-during-write
// behaviour, 1- or 2-cycle read latency and deterministic write-collision merge.
module dual_port_ram_param
   import dpram_pkg::*;
#(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned DEPTH     = 64,
   parameter int unsigned ADDR_W    = $clog2(DEPTH),
   parameter int unsigned RD_LAT    = 1,
   parameter rdw_mode_e   RDW_MODE  = NO_CHANGE,
   parameter bit          WR_PRIO_A = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en_a,
   input  logic                 we_a,
   input  logic [DATA_W/8-1:0]  be_a,
   input  logic [ADDR_W-1:0]    addr_a,
   input  logic [DATA_W-1:0]    data_a,
   output logic [DATA_W-1:0]    q_a,
   output logic                 qv_a,
   input  logic                 en_b,
   input  logic                 we_b,
   input  logic [DATA_W/8-1:0]  be_b,
   input  logic [ADDR_W-1:0]    addr_b,
   input  logic [DATA_W-1:0]    data_b,
   output logic [DATA_W-1:0]    q_b,
   output logic                 qv_b,
   output logic                 collision
);

   localparam int unsigned NLANES = DATA_W / LANE_W;

   logic [DATA_W-1:0] mem [DEPTH];

   logic              wr_a_c, wr_b_c, coll_c;
   logic              ret_a_c, ret_b_c;
   logic [DATA_W-1:0] old_a_c, old_b_c;
   logic [DATA_W-1:0] new_a_c, new_b_c, merged_c;
   logic [DATA_W-1:0] fin_a_c, fin_b_c;
   logic [DATA_W-1:0] ret_a_d_c, ret_b_d_c;

   logic              s1_vld_a, s1_vld_b;
   logic [DATA_W-1:0] s1_data_a, s1_data_b;

   function automatic logic [DATA_W-1:0] merge(
      input logic [DATA_W-1:0] old_w,
      input logic [DATA_W-1:0] new_w,
      input logic [NLANES-1:0] be
   );
      return DATA_W'(lane_merge(MAX_W'(old_w), MAX_W'(new_w), MAX_LANES'(be)));
   endfunction

   // Final word per port: on a collision the loser's lanes go in first, winner's on top.
   always_comb begin
      old_a_c  = mem[addr_a];
      old_b_c  = mem[addr_b];
      wr_a_c   = en_a & we_a;
      wr_b_c   = en_b & we_b;
      coll_c   = wr_a_c & wr_b_c & (addr_a == addr_b);
      new_a_c  = merge(old_a_c, data_a, be_a);
      new_b_c  = merge(old_b_c, data_b, be_b);
      merged_c = WR_PRIO_A ? merge(new_b_c, data_a, be_a)
                           : merge(new_a_c, data_b, be_b);
      fin_a_c  = coll_c ? merged_c : new_a_c;
      fin_b_c  = coll_c ? merged_c : new_b_c;

      ret_a_c   = en_a & (~we_a | (RDW_MODE != NO_CHANGE));
      ret_b_c   = en_b & (~we_b | (RDW_MODE != NO_CHANGE));
      ret_a_d_c = (we_a && RDW_MODE == WRITE_FIRST) ? fin_a_c : old_a_c;
      ret_b_d_c = (we_b && RDW_MODE == WRITE_FIRST) ? fin_b_c : old_b_c;
   end

   // Storage is deliberately not reset; accesses during rst are dropped.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (wr_a_c) mem[addr_a] <= fin_a_c;
         if (wr_b_c) mem[addr_b] <= fin_b_c;
      end
   end

   // First read stage and collision flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_vld_a  <= 1'b0;
         s1_vld_b  <= 1'b0;
         s1_data_a <= '0;
         s1_data_b <= '0;
         collision <= 1'b0;
      end else begin
         s1_vld_a  <= ret_a_c;
         s1_vld_b  <= ret_b_c;
         if (ret_a_c) s1_data_a <= ret_a_d_c;
         if (ret_b_c) s1_data_b <= ret_b_d_c;
         collision <= coll_c;
      end
   end

   dpram_rd_pipe #(
      .DATA_W (DATA_W),
      .RD_LAT (RD_LAT)
   ) u_pipe_a (
      .clk     (clk),
      .rst     (rst),
      .s1_vld  (s1_vld_a),
      .s1_data (s1_data_a),
      .q       (q_a),
      .qv      (qv_a)
   );

   dpram_rd_pipe #(
      .DATA_W (DATA_W),
      .RD_LAT (RD_LAT)
   ) u_pipe_b (
      .clk     (clk),
      .rst     (rst),
      .s1_vld  (s1_vld_b),
      .s1_data (s1_data_b),
      .q       (q_b),
      .qv      (qv_b)
   );

endmodule

// File: tb/tb_dual_port_ram_param.sv
// Bench: three RAM configurations driven by shared stimulus, checked every cycle
// against a per-word behavioural model, plus directed literal checks.
module tb_dual_port_ram_param;
   import dpram_pkg::*;

   localparam int DW   [3] = '{32, 16, 32};
   localparam int LAT  [3] = '{1, 2, 2};
   localparam int MODE [3] = '{0, 1, 2};   // 0 no-change, 1 read-first, 2 write-first
   localparam int PRIO [3] = '{1, 0, 1};   // 1 = port A wins

   logic        clk = 1'b0;
   logic        rst;
   logic        en_a, we_a, en_b, we_b;
   logic [3:0]  be_a, be_b, addr_a, addr_b;
   logic [31:0] data_a, data_b;

   logic [31:0] q0a, q0b, q2a, q2b;
   logic [15:0] q1a, q1b;
   logic        qv0a, qv0b, qv1a, qv1b, qv2a, qv2b, c0, c1, c2;

   always #5 clk = ~clk;

   dual_port_ram_param #(.DATA_W(32), .DEPTH(16), .RD_LAT(1), .RDW_MODE(NO_CHANGE), .WR_PRIO_A(1'b1)) u0 (
      .clk(clk), .rst(rst),
      .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .data_a(data_a), .q_a(q0a), .qv_a(qv0a),
      .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .data_b(data_b), .q_b(q0b), .qv_b(qv0b),
      .collision(c0));

   dual_port_ram_param #(.DATA_W(16), .DEPTH(16), .RD_LAT(2), .RDW_MODE(READ_FIRST), .WR_PRIO_A(1'b0)) u1 (
      .clk(clk), .rst(rst),
      .en_a(en_a), .we_a(we_a), .be_a(be_a[1:0]), .addr_a(addr_a), .data_a(data_a[15:0]), .q_a(q1a), .qv_a(qv1a),
      .en_b(en_b), .we_b(we_b), .be_b(be_b[1:0]), .addr_b(addr_b), .data_b(data_b[15:0]), .q_b(q1b), .qv_b(qv1b),
      .collision(c1));

   dual_port_ram_param #(.DATA_W(32), .DEPTH(16), .RD_LAT(2), .RDW_MODE(WRITE_FIRST), .WR_PRIO_A(1'b1)) u2 (
      .clk(clk), .rst(rst),
      .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .data_a(data_a), .q_a(q2a), .qv_a(qv2a),
      .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .data_b(data_b), .q_b(q2b), .qv_b(qv2b),
      .collision(c2));

   logic [31:0] dq  [3][2];
   logic        dqv [3][2];
   logic        dcol [3];

   always_comb begin
      dq[0][0] = q0a;            dq[0][1] = q0b;
      dq[1][0] = {16'h0, q1a};   dq[1][1] = {16'h0, q1b};
      dq[2][0] = q2a;            dq[2][1] = q2b;
      dqv[0][0] = qv0a; dqv[0][1] = qv0b;
      dqv[1][0] = qv1a; dqv[1][1] = qv1b;
      dqv[2][0] = qv2a; dqv[2][1] = qv2b;
      dcol[0] = c0; dcol[1] = c1; dcol[2] = c2;
   end

   int tests = 0;
   int fails = 0;
   bit chk_on = 1'b0;
   bit live   = 1'b0;
   int ncyc   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [31:0] mm   [3][16];
   logic [31:0] eq   [3][2];
   logic        eqv  [3][2];
   logic        ecol [3];
   logic [31:0] sd   [3][2][4];   // response due at edge index mod 4
   logic        sv   [3][2][4];

   task automatic model_edge(input int k);
      logic [31:0] old [2];
      logic [31:0] fin [2];
      logic [31:0] dt  [2];
      logic [3:0]  be  [2];
      logic [3:0]  ad  [2];
      logic        en  [2];
      logic        we  [2];
      logic [31:0] w;
      logic [31:0] rd;
      logic        rv, col;
      int          win, los, nl, slot;
      if (rst) begin
         for (int p = 0; p < 2; p++) begin
            eq[k][p]  = '0;
            eqv[k][p] = 1'b0;
            for (int s = 0; s < 4; s++) sv[k][p][s] = 1'b0;
         end
         ecol[k] = 1'b0;
         return;
      end
      en[0] = en_a;  we[0] = we_a;  be[0] = be_a;  ad[0] = addr_a;  dt[0] = data_a;
      en[1] = en_b;  we[1] = we_b;  be[1] = be_b;  ad[1] = addr_b;  dt[1] = data_b;
      nl  = DW[k] / 8;
      col = en[0] & we[0] & en[1] & we[1] & (ad[0] == ad[1]);
      win = (PRIO[k] == 1) ? 0 : 1;
      los = 1 - win;
      for (int p = 0; p < 2; p++) begin
         old[p] = mm[k][ad[p]];
         fin[p] = old[p];
         for (int i = 0; i < nl; i++)
            if (be[p][i]) fin[p][8*i +: 8] = dt[p][8*i +: 8];
      end
      if (col) begin
         w = old[0];
         for (int i = 0; i < nl; i++) begin
            if (be[win][i])      w[8*i +: 8] = dt[win][8*i +: 8];
            else if (be[los][i]) w[8*i +: 8] = dt[los][8*i +: 8];
         end
         fin[0] = w;
         fin[1] = w;
      end
      for (int p = 0; p < 2; p++) begin
         rv = 1'b0;
         rd = '0;
         if (en[p] && !we[p]) begin
            rv = 1'b1; rd = old[p];
         end else if (en[p] && we[p] && MODE[k] == 1) begin
            rv = 1'b1; rd = old[p];
         end else if (en[p] && we[p] && MODE[k] == 2) begin
            rv = 1'b1; rd = fin[p];
         end
         slot = (ncyc + LAT[k] - 1) % 4;
         sv[k][p][slot] = rv;
         sd[k][p][slot] = rd;
         slot = ncyc % 4;
         eqv[k][p] = sv[k][p][slot];
         if (sv[k][p][slot]) eq[k][p] = sd[k][p][slot];
         sv[k][p][slot] = 1'b0;
      end
      for (int p = 0; p < 2; p++)
         if (en[p] && we[p]) mm[k][ad[p]] = fin[p];
      ecol[k] = col;
   endtask

   initial begin
      for (int k = 0; k < 3; k++)
         for (int a = 0; a < 16; a++) mm[k][a] = '0;
      forever begin
         @(posedge clk);
         ncyc++;
         for (int k = 0; k < 3; k++) model_edge(k);
         if (rst) live = 1'b1;
      end
   end

   // ---------------- per-cycle compare ----------------
   initial begin
      forever begin
         @(negedge clk);
         if (live && chk_on) begin
            for (int k = 0; k < 3; k++) begin
               for (int p = 0; p < 2; p++) begin
                  chk($sformatf("u%0d_qv_%s", k, p == 0 ? "a" : "b"), {31'b0, dqv[k][p]}, {31'b0, eqv[k][p]});
                  chk($sformatf("u%0d_q_%s", k, p == 0 ? "a" : "b"), dq[k][p], eq[k][p]);
               end
               chk($sformatf("u%0d_collision", k), {31'b0, dcol[k]}, {31'b0, ecol[k]});
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      en_a = 1'b0; we_a = 1'b0; be_a = '0; addr_a = '0; data_a = '0;
      en_b = 1'b0; we_b = 1'b0; be_b = '0; addr_b = '0; data_b = '0;
   endtask

   task automatic set_a(input logic we, input logic [3:0] be, input logic [3:0] ad, input logic [31:0] d);
      en_a = 1'b1; we_a = we; be_a = be; addr_a = ad; data_a = d;
   endtask

   task automatic set_b(input logic we, input logic [3:0] be, input logic [3:0] ad, input logic [31:0] d);
      en_b = 1'b1; we_b = we; be_b = be; addr_b = ad; data_b = d;
   endtask

   initial begin
      rst = 1'b1;
      idle();
      repeat (2) cyc();
      chk("rst_u0_q_a", q0a, 32'h0);
      chk("rst_u0_qv_a", {31'b0, qv0a}, 32'h0);
      chk("rst_u2_q_a", q2a, 32'h0);
      chk("rst_u2_qv_a", {31'b0, qv2a}, 32'h0);
      chk("rst_u2_collision", {31'b0, c2}, 32'h0);
      rst = 1'b0;

      // Two zero-fill passes: the second leaves every return path with known data.
      for (int pass = 0; pass < 2; pass++)
         for (int a = 0; a < 16; a++) begin
            idle(); set_a(1'b1, 4'hF, 4'(a), 32'h0); cyc();
         end
      idle(); repeat (2) cyc();
      chk_on = 1'b1;

      // Readback through the other port, latency 1 vs 2.
      idle(); set_a(1'b1, 4'h1, 4'd3, 32'h0000_00A5); cyc();
      idle(); set_b(1'b0, 4'h0, 4'd3, 32'h0); cyc();
      chk("rb_u0_q_b", q0b, 32'h0000_00A5);
      chk("rb_u0_qv_b", {31'b0, qv0b}, 32'h1);
      chk("rb_u2_qv_b_early", {31'b0, qv2b}, 32'h0);
      idle(); cyc();
      chk("rb_u2_q_b", q2b, 32'h0000_00A5);
      chk("rb_u2_qv_b", {31'b0, qv2b}, 32'h1);
      chk("rb_u1_q_b", {16'h0, q1b}, 32'h0000_00A5);
      chk("rb_u0_qv_b_once", {31'b0, qv0b}, 32'h0);

      // Byte enables.
      idle(); set_a(1'b1, 4'hF, 4'd5, 32'h1122_3344); cyc();
      idle(); set_a(1'b1, 4'b0101, 4'd5, 32'hAABB_CCDD); cyc();
      idle(); set_b(1'b0, 4'h0, 4'd5, 32'h0); cyc();
      chk("be_u0_q_b", q0b, 32'h11BB_33DD);
      idle(); cyc();
      chk("be_u2_q_b", q2b, 32'h11BB_33DD);
      chk("be_u1_q_b", {16'h0, q1b}, 32'h0000_33DD);

      // Same-port read-during-write.
      idle(); set_a(1'b1, 4'hF, 4'd7, 32'h10); cyc();
      idle(); set_a(1'b0, 4'h0, 4'd7, 32'h0); cyc();
      idle(); cyc();
      idle(); set_a(1'b1, 4'hF, 4'd7, 32'h20); cyc();
      chk("rdw_u0_qv_a", {31'b0, qv0a}, 32'h0);
      chk("rdw_u0_q_a_hold", q0a, 32'h10);
      idle(); cyc();
      chk("rdw_u1_q_a", {16'h0, q1a}, 32'h10);
      chk("rdw_u1_qv_a", {31'b0, qv1a}, 32'h1);
      chk("rdw_u2_q_a", q2a, 32'h20);
      chk("rdw_u2_qv_a", {31'b0, qv2a}, 32'h1);

      // Cross-port write/read, then dual read of the same word.
      idle(); set_a(1'b1, 4'hF, 4'd9, 32'h55); set_b(1'b0, 4'h0, 4'd9, 32'h0); cyc();
      chk("xp_u0_q_b_old", q0b, 32'h0);
      chk("xp_u0_qv_b", {31'b0, qv0b}, 32'h1);
      idle(); set_a(1'b0, 4'h0, 4'd9, 32'h0); set_b(1'b0, 4'h0, 4'd9, 32'h0); cyc();
      chk("xp_u0_q_b_new", q0b, 32'h55);
      chk("dr_u0_q_a", q0a, 32'h55);
      chk("dr_u0_collision", {31'b0, c0}, 32'h0);

      // Write collision.
      idle(); set_a(1'b1, 4'b0001, 4'd2, 32'h1234); set_b(1'b1, 4'b0011, 4'd2, 32'hABCD); cyc();
      chk("col_u2_flag", {31'b0, c2}, 32'h1);
      chk("col_u1_flag", {31'b0, c1}, 32'h1);
      idle(); set_b(1'b0, 4'h0, 4'd2, 32'h0); cyc();
      chk("col_u2_flag_drop", {31'b0, c2}, 32'h0);
      chk("col_u2_wf_q_a", q2a, 32'h0000_AB34);
      chk("col_u2_wf_q_b", q2b, 32'h0000_AB34);
      chk("col_u0_q_b", q0b, 32'h0000_AB34);
      idle(); cyc();
      chk("col_u2_rd_q_b", q2b, 32'h0000_AB34);
      chk("col_u1_rd_q_b", {16'h0, q1b}, 32'h0000_ABCD);

      // Reset with a read in flight.
      idle(); set_a(1'b1, 4'hF, 4'd1, 32'h77); cyc();
      idle(); set_b(1'b0, 4'h0, 4'd1, 32'h0); cyc();
      idle(); rst = 1'b1; cyc();
      chk("mrst_u2_qv_b", {31'b0, qv2b}, 32'h0);
      chk("mrst_u2_q_b", q2b, 32'h0);
      rst = 1'b0; cyc();
      chk("mrst_u2_qv_b_after", {31'b0, qv2b}, 32'h0);
      idle(); set_b(1'b0, 4'h0, 4'd1, 32'h0); cyc();
      idle(); cyc();
      chk("mrst_u2_q_b_kept", q2b, 32'h77);
      chk("mrst_u2_qv_b_kept", {31'b0, qv2b}, 32'h1);

      // Random traffic concentrated on a few addresses to provoke collisions.
      for (int i = 0; i < 3000; i++) begin
         rst    = ($urandom_range(0, 63) == 0);
         en_a   = ($urandom_range(0, 3) != 0);
         we_a   = 1'($urandom_range(0, 1));
         be_a   = 4'($urandom);
         addr_a = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
         data_a = $urandom;
         en_b   = ($urandom_range(0, 3) != 0);
         we_b   = 1'($urandom_range(0, 1));
         be_b   = 4'($urandom);
         addr_b = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
         data_b = $urandom;
         cyc();
      end
      rst = 1'b0;
      idle();
      repeat (3) cyc();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/dual_port_ram_param.md
Name: dual_port_ram_param

Overview:
- Parametrised true dual-port synchronous RAM. Generalises the existing 8x64 dual-port RAM in width, depth, byte-lane writes, read-during-write mode and read latency.
- Adds explicit read-valid outputs, deterministic write-collision resolution and a collision flag.
- Used as the common storage primitive for FIFOs, frame buffers and register files in the memory subsystem.

Parameters:
- DATA_W, 8, data word width in bits; must be a multiple of 8.
- DEPTH, 64, number of words; power of two, minimum 2.
- ADDR_W, $clog2(DEPTH), address width; derived, never overridden.
- RD_LAT, 1, read latency in cycles; legal values 1 or 2. Value 2 adds one output register stage.
- RDW_MODE, NO_CHANGE, same-port read-during-write behaviour: NO_CHANGE, READ_FIRST or WRITE_FIRST.
- WR_PRIO_A, 1, write-collision winner: 1 = port A, 0 = port B.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- en_a  in  1  port A access enable.
- we_a  in  1  port A write enable; qualified by en_a.
- be_a  in  DATA_W/8  port A byte enables; qualified by we_a.
- addr_a  in  ADDR_W  port A address.
- data_a  in  DATA_W  port A write data.
- q_a  out  DATA_W  port A read data.
- qv_a  out  1  port A read-data valid.
- en_b, we_b, be_b, addr_b, data_b, q_b, qv_b: port B, identical to port A.
- collision  out  1  registered pulse: both ports wrote the same address in one cycle.

Behaviour:
- Reset: rst is sampled only on posedge clk.
  - q_a, q_b clear to 0; qv_a, qv_b, collision clear to 0; all pipeline stages flush.
  - Memory contents are NOT cleared.
  - Accesses presented in the same cycle as rst are ignored, writes included.
  - After rst deasserts, the first access is accepted on the next edge.
- Write: at posedge with en_x & we_x & !rst:
  - each lane i with be_x[i]=1 gets mem[addr_x][8i+7:8i] <= data_x lane i;
  - lanes with be_x[i]=0 are untouched;
  - we_x with be_x = 0 is a no-op write.
- Read (en_x & !we_x): with RD_LAT=1, q_x/qv_x update at the first edge after the access. With RD_LAT=2, they update at the second edge.
- qv_x:
  - asserts for exactly one cycle per completed read;
  - for writes, asserts only in READ_FIRST or WRITE_FIRST mode.
- q_x holds its last value whenever qv_x=0 (no-access cycles and NO_CHANGE writes).
- Same-port read-during-write (en_x & we_x), by RDW_MODE:
  - NO_CHANGE: q_x holds; qv_x=0.
  - READ_FIRST: q_x = old word; qv_x=1.
  - WRITE_FIRST: q_x = merged new word (enabled lanes new, others old); qv_x=1.
- Cross-port write/read, same address, same cycle: the reading port always returns the old word (read-first across ports).
- Write collision: both ports write the same address in one cycle.
  - Lanes enabled by the winner take the winner's data.
  - Lanes enabled only by the loser take the loser's data.
  - collision=1 on the next cycle for exactly one cycle.
  - The WRITE_FIRST return on each port reflects the final merged word.
- Two reads of the same address in one cycle are legal and both return identical data; no collision is flagged.
- Addresses wrap naturally modulo DEPTH; with DEPTH a power of two, no out-of-range address exists.
- RD_LAT=2 pipeline: fully pipelined, accepting one access per port per cycle. Stage 2 advances unconditionally, with no stall and no backpressure.
- Mid-operation rst drops all in-flight reads: no qv pulse follows for them.

Decomposition:
- Package dpram_pkg holds:
  - the enum rdw_mode_e {NO_CHANGE, READ_FIRST, WRITE_FIRST};
  - the function lane_merge(old, new, be), used by the write path and by WRITE_FIRST return data;
  - localparam LANE_W = 8.
- Sub-module dpram_rd_pipe is instantiated once per port. It implements the optional second register stage and its valid, including the reset flush.
- The memory array and collision logic stay in the top module.

Test Plan:
- Reset/readback: after rst, write 0xA5 to A@3 with be=1; read B@3 -> q_b=0xA5 with qv_b=1 exactly 1 cycle later (RD_LAT=1) or 2 cycles later (RD_LAT=2); q_a=0, qv_a=0 throughout reset.
- Byte enables (DATA_W=32): preload @5 = 0x11223344; write 0xAABBCCDD with be=4'b0101 -> read @5 returns 0x11BB33DD.
- RDW modes: preload @7 = 0x10; port A writes 0x20@7 with a read-during-write return:
  - NO_CHANGE -> q_a holds its prior value, qv_a=0;
  - READ_FIRST -> q_a=0x10;
  - WRITE_FIRST -> q_a=0x20.
- Cross-port: port A writes 0x55@9 while port B reads @9 (old value 0x00) -> q_b=0x00; B reads again next cycle -> 0x55.
- Collision (WR_PRIO_A=1, DATA_W=16): A writes 0x1234 be=2'b01, B writes 0xABCD be=2'b11 to @2 -> mem[2]=0xAB34; collision high for exactly 1 cycle.
- Reset mid-flight (RD_LAT=2): issue B read @1, assert rst on the next edge -> no qv_b pulse and q_b=0; the first post-reset read returns the preserved memory value.
